// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and default sizes for the CAM controller,
//               decoder and array.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int CAM_WIDTH      = 32;
    localparam int CAM_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SEARCH = 2'b10,
        OP_NOP    = 2'b11
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } cam_state_e;

endpackage
`default_nettype wire

// File: rtl/cam_priority_enc.sv
`default_nettype none
// ============================================================================
// Module      : cam_priority_enc
// Description : Combinational priority encoder for CAM match lines. Bit 0
//               has the highest priority. Optional multi-hit flag is built
//               when CAM_CTRL_MULTIHIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_priority_enc #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [DEPTH-1:0]      i_match,
`ifdef CAM_CTRL_MULTIHIT_EN
    output logic                  o_multi_hit,
`endif
    output logic                  o_hit,
    output logic [ADDR_WIDTH-1:0] o_index
);

    // Scan upward so the first set bit found is the lowest index
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
`ifdef CAM_CTRL_MULTIHIT_EN
        o_multi_hit = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (i_match[i]) begin
`ifdef CAM_CTRL_MULTIHIT_EN
                if (o_hit) begin
                    o_multi_hit = 1'b1;
                end
`endif
                if (!o_hit) begin
                    o_index = ADDR_WIDTH'(i);
                end
                o_hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_ctrl
// Description : CAM command sequencer. Accepts READ/WRITE/SEARCH/NOP
//               requests, pulses the decoder enable for one cycle, captures
//               array data / match lines and returns one response per request.
//               Optional rsp_multi_hit_o output under CAM_CTRL_MULTIHIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH      = CAM_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [ADDR_WIDTH-1:0] req_index_i,
    input  logic [WIDTH-1:0]      req_data_i,
    output logic                  read_enable_o,
    output logic [ADDR_WIDTH-1:0] read_index_o,
    output logic                  write_enable_o,
    output logic [ADDR_WIDTH-1:0] write_index_o,
    output logic                  search_enable_o,
    output logic [WIDTH-1:0]      data_o,
    input  logic [WIDTH-1:0]      read_data_i,
    input  logic [DEPTH-1:0]      match_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
`ifdef CAM_CTRL_MULTIHIT_EN
    output logic                  rsp_multi_hit_o,
`endif
    output logic                  rsp_hit_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic [WIDTH-1:0]      rsp_data_o
);

    cam_state_e            r_state;
    cam_op_e               r_op;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [WIDTH-1:0]      r_data;
    logic                  r_rsp_hit;
    logic [ADDR_WIDTH-1:0] r_rsp_index;
    logic [WIDTH-1:0]      r_rsp_data;

    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_issue;

`ifdef CAM_CTRL_MULTIHIT_EN
    logic                  w_multi_hit;
    logic                  r_rsp_multi_hit;
`endif

    cam_priority_enc #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio (
        .i_match     (match_i),
`ifdef CAM_CTRL_MULTIHIT_EN
        .o_multi_hit (w_multi_hit),
`endif
        .o_hit       (w_hit),
        .o_index     (w_index)
    );

    // Sequencer FSM: latch request, issue one enable, capture, hold response
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_index     <= '0;
            r_data      <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_index <= '0;
            r_rsp_data  <= '0;
`ifdef CAM_CTRL_MULTIHIT_EN
            r_rsp_multi_hit <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_op    <= cam_op_e'(req_op_i);
                        r_index <= req_index_i;
                        r_data  <= req_data_i;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_rsp_data <= r_data;
                    case (r_op)
                        OP_READ: begin
                            r_rsp_hit   <= 1'b1;
                            r_rsp_index <= r_index;
                            r_rsp_data  <= read_data_i;
                        end
                        OP_WRITE: begin
                            r_rsp_hit   <= 1'b1;
                            r_rsp_index <= r_index;
                        end
                        OP_SEARCH: begin
                            r_rsp_hit   <= w_hit;
                            r_rsp_index <= w_index;
                        end
                        default: begin
                            r_rsp_hit   <= 1'b0;
                            r_rsp_index <= '0;
                        end
                    endcase
`ifdef CAM_CTRL_MULTIHIT_EN
                    r_rsp_multi_hit <= (r_op == OP_SEARCH) && w_multi_hit;
`endif
                    r_state <= ST_RESP;
                end
                default: begin
                    if (rsp_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Enables are a pure decode of ISSUE and the latched op; NOP decodes to none
    always_comb begin
        w_issue         = (r_state == ST_ISSUE);
        read_enable_o   = w_issue && (r_op == OP_READ);
        write_enable_o  = w_issue && (r_op == OP_WRITE);
        search_enable_o = w_issue && (r_op == OP_SEARCH);
    end

    assign read_index_o  = r_index;
    assign write_index_o = r_index;
    assign data_o        = r_data;
    assign req_ready_o   = (r_state == ST_IDLE);
    assign rsp_valid_o   = (r_state == ST_RESP);
    assign rsp_hit_o     = r_rsp_hit;
    assign rsp_index_o   = r_rsp_index;
    assign rsp_data_o    = r_rsp_data;
`ifdef CAM_CTRL_MULTIHIT_EN
    assign rsp_multi_hit_o = r_rsp_multi_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_ctrl
// Description : Self-checking bench for cam_ctrl with a small array model
//               and an expected-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_ctrl;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 1 << AW;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = 2'b11;
    logic [AW-1:0] req_index_i = '0;
    logic [W-1:0]  req_data_i = '0;
    logic          read_enable_o, write_enable_o, search_enable_o;
    logic [AW-1:0] read_index_o, write_index_o;
    logic [W-1:0]  data_o;
    logic [W-1:0]  read_data_i = '0;
    logic [D-1:0]  match_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic          rsp_hit_o;
    logic [AW-1:0] rsp_index_o;
    logic [W-1:0]  rsp_data_o;
`ifdef CAM_CTRL_MULTIHIT_EN
    logic          rsp_multi_hit_o;
`endif

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    logic [W-1:0] arr_mem [D];
    logic [W-1:0] ref_mem [D];
    logic [D-1:0] cfg_match = '0;

    typedef struct {
        logic          hit;
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
        logic          multi;
        logic          full;
    } exp_t;
    exp_t sb[$];

    cam_ctrl dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_index_i     (req_index_i),
        .req_data_i      (req_data_i),
        .read_enable_o   (read_enable_o),
        .read_index_o    (read_index_o),
        .write_enable_o  (write_enable_o),
        .write_index_o   (write_index_o),
        .search_enable_o (search_enable_o),
        .data_o          (data_o),
        .read_data_i     (read_data_i),
        .match_i         (match_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
`ifdef CAM_CTRL_MULTIHIT_EN
        .rsp_multi_hit_o (rsp_multi_hit_o),
`endif
        .rsp_hit_o       (rsp_hit_o),
        .rsp_index_o     (rsp_index_o),
        .rsp_data_o      (rsp_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Array model: write/read/search answered the cycle after the enable
    always @(posedge clk_i) begin
        if (write_enable_o) arr_mem[write_index_o] <= data_o;
        if (read_enable_o)  read_data_i <= arr_mem[read_index_o];
        if (search_enable_o) match_i <= cfg_match;
        if (read_enable_o || write_enable_o || search_enable_o) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input exp_t e);
        chk({tag, "_hit"}, 64'(rsp_hit_o), 64'(e.hit));
        if (e.full) begin
            chk({tag, "_idx"},  64'(rsp_index_o), 64'(e.idx));
            chk({tag, "_data"}, 64'(rsp_data_o),  64'(e.data));
        end
`ifdef CAM_CTRL_MULTIHIT_EN
        chk({tag, "_multi"}, 64'(rsp_multi_hit_o), 64'(e.multi));
`endif
    endtask

    // One complete request/response transaction with optional backpressure
    task automatic do_op(input string tag, input logic [1:0] op, input logic [AW-1:0] idx,
                         input logic [W-1:0] dat, input logic [D-1:0] match, input int hold);
        exp_t e;
        exp_t got;
        int   e0;
        int   cnt;
        e.hit = 1'b0; e.idx = '0; e.data = dat; e.multi = 1'b0; e.full = 1'b1;
        case (op)
            2'b00: begin e.hit = 1'b1; e.idx = idx; e.data = ref_mem[idx]; end
            2'b01: begin e.hit = 1'b1; e.idx = idx; ref_mem[idx] = dat; end
            2'b10: begin
                cnt = 0;
                for (int i = D - 1; i >= 0; i--) begin
                    if (match[i]) begin e.idx = AW'(i); cnt++; end
                end
                e.hit = (cnt > 0);
                e.multi = (cnt > 1);
            end
            default: e.full = 1'b0;
        endcase
        sb.push_back(e);

        @(negedge clk_i);
        chk({tag, "_rdy_idle"}, 64'(req_ready_o), 64'd1);
        cfg_match   = match;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_index_i = idx;
        req_data_i  = dat;
        e0 = en_cnt;

        @(negedge clk_i);  // ISSUE (T+1)
        req_valid_i = 1'b0;
        req_op_i    = 2'b11;
        chk({tag, "_rdy_busy"}, 64'(req_ready_o), 64'd0);
        chk({tag, "_en"}, 64'({read_enable_o, write_enable_o, search_enable_o}),
            64'({op == 2'b00, op == 2'b01, op == 2'b10}));
        if (op == 2'b00) chk({tag, "_ridx"}, 64'(read_index_o), 64'(idx));
        if (op == 2'b01) chk({tag, "_widx"}, 64'(write_index_o), 64'(idx));
        chk({tag, "_data_o"}, 64'(data_o), 64'(dat));

        @(negedge clk_i);  // CAPTURE (T+2)
        chk({tag, "_cap_en"}, 64'({read_enable_o, write_enable_o, search_enable_o}), 64'd0);
        chk({tag, "_cap_vld"}, 64'(rsp_valid_o), 64'd0);

        @(negedge clk_i);  // RESP (T+3)
        chk({tag, "_rsp_vld"}, 64'(rsp_valid_o), 64'd1);
        got = sb.pop_front();
        chk_rsp(tag, got);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk_i);
            chk({tag, "_bp_vld"}, 64'(rsp_valid_o), 64'd1);
            chk({tag, "_bp_rdy"}, 64'(req_ready_o), 64'd0);
            chk_rsp({tag, "_bp"}, got);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk({tag, "_done_vld"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_done_rdy"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_en_count"}, 64'(en_cnt - e0), 64'(op != 2'b11));
    endtask

    initial begin
        for (int i = 0; i < D; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk_i);
        chk("rst_rdy",  64'(req_ready_o), 64'd1);
        chk("rst_vld",  64'(rsp_valid_o), 64'd0);
        chk("rst_en",   64'({read_enable_o, write_enable_o, search_enable_o}), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_rsp",  64'({rsp_hit_o, rsp_index_o, rsp_data_o}), 64'd0);
        reset_i = 1'b0;

        do_op("wr5",   2'b01, 5'd5,  32'hDEADBEEF, '0, 0);
        do_op("rd5",   2'b00, 5'd5,  32'h0,        '0, 0);
        do_op("wr9",   2'b01, 5'd9,  32'h12345678, '0, 0);
        do_op("rd9bp", 2'b00, 5'd9,  32'h0,        '0, 10);
        do_op("srch",  2'b10, 5'd3,  32'hDEADBEEF, 32'h0000_0A00, 0);
        do_op("miss",  2'b10, 5'd7,  32'hDEADBEEF, 32'h0, 0);
        do_op("top",   2'b10, 5'd0,  32'hCAFEF00D, 32'h8000_0000, 0);
        do_op("bit0",  2'b10, 5'd0,  32'h1,        32'hFFFF_FFFF, 2);
        do_op("nop",   2'b11, 5'd3,  32'h000000AA, '0, 0);

        // Reset during CAPTURE of a SEARCH: op is dropped
        @(negedge clk_i);
        cfg_match   = 32'h0000_0010;
        req_valid_i = 1'b1;
        req_op_i    = 2'b10;
        req_index_i = 5'd1;
        req_data_i  = 32'h55AA55AA;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rstcap_state", 64'(rsp_valid_o), 64'd0);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rstcap_rdy",  64'(req_ready_o), 64'd1);
        chk("rstcap_data", 64'(data_o), 64'd0);
        chk("rstcap_rsp",  64'({rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o}), 64'd0);
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("rstcap_novld", 64'(rsp_valid_o), 64'd0);
            chk("rstcap_idle",  64'(req_ready_o), 64'd1);
        end

        // Array content survives the controller reset
        do_op("rd5b", 2'b00, 5'd5, 32'h0, '0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
